// File: rtl/zombie_pkg.sv
// Sprite-sheet geometry and per-slot configuration types shared by the
// zombie sprite engine and its slot sub-module.
package zombie_pkg;

    localparam int FRAME_W         = 48;
    localparam int FRAME_H         = 64;
    localparam int FRAMES          = 4;
    localparam int SHEET_W         = 576;
    localparam int ACTION_STRIDE   = 192;
    localparam int TYPE_STRIDE     = 36864;
    localparam int TRANSPARENT_IDX = 0;

    typedef enum logic [1:0] {
        WALK = 2'd0,
        EAT  = 2'd1,
        DIE  = 2'd2
    } zombie_action_e;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [1:0] ztype;
        logic [1:0] action;
        logic       flip;
        logic       en;
    } slot_cfg_t;

    // Linear sheet offset of one texel; wide enough that no term overflows.
    function automatic logic [19:0] sheet_offset(input logic [5:0] dy,
                                                 input logic [5:0] col,
                                                 input logic [1:0] frame,
                                                 input logic [1:0] action,
                                                 input logic [1:0] ztype);
        return 20'(dy) * 20'(SHEET_W) + 20'(col)
             + 20'(frame)  * 20'(FRAME_W)
             + 20'(action) * 20'(ACTION_STRIDE)
             + 20'(ztype)  * 20'(TYPE_STRIDE);
    endfunction

endpackage

// File: rtl/zombie_slot.sv
// One zombie instance: double-buffered configuration, animation frame counter,
// and the combinational hit test / sheet address for the current pixel.
module zombie_slot
    import zombie_pkg::*;
#(
    parameter logic [1:0] ONESHOT_ACTION = DIE
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    input  logic        frame_start,
    input  logic        step,
    input  logic        shadow_we,
    input  slot_cfg_t   cfg,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic        hit,
    output logic [19:0] addr
);

    slot_cfg_t  shadow, active, eff;
    logic [1:0] frame, frame_next;
    logic       restart;
    logic [10:0] dx, dy;
    logic [5:0]  col;

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; the commit therefore sees the shadow before a same-cycle write.
    // NOTE: slot registers are plain flops, not a RAM, so reset clears them all
    // and a mid-frame reset hides every zombie at once.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow <= '0;
            active <= '0;
            frame  <= '0;
        end else begin
            if (shadow_we)
                shadow <= cfg;
            if (frame_start) begin
                active <= shadow;
                frame  <= frame_next;
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        restart    = (shadow.ztype  != active.ztype)
                  || (shadow.action != active.action)
                  || (shadow.en && !active.en);
        frame_next = frame;
        if (frame_start) begin
            if (restart)
                frame_next = '0;
            else if (step) begin
                if (shadow.action == ONESHOT_ACTION)
                    frame_next = (frame == 2'(FRAMES - 1)) ? frame : frame + 2'd1;
                else
                    frame_next = frame + 2'd1;
            end
        end
    end

    // Forward the commit so the frame_start pixel already uses the new set.
    always_comb begin
        eff  = frame_start ? shadow : active;
        dx   = {1'b0, DrawX} - {1'b0, eff.x};
        dy   = {1'b0, DrawY} - {1'b0, eff.y};
        hit  = eff.en && (DrawX >= eff.x) && (DrawY >= eff.y)
            && (dx < 11'(FRAME_W)) && (dy < 11'(FRAME_H));
        col  = eff.flip ? 6'(FRAME_W - 1) - dx[5:0] : dx[5:0];
        addr = sheet_offset(dy[5:0], col, frame_next, eff.action, eff.ztype);
    end

endmodule

// File: rtl/zombie_sprite_engine.sv
// Multi-slot zombie renderer: animation divider, lowest-index priority mux and
// the three-stage address -> ROM -> pixel pipeline.
module zombie_sprite_engine
    import zombie_pkg::*;
#(
    parameter int         N_SLOTS        = 8,
    parameter int         ANIM_DIV       = 6,
    parameter logic [1:0] ONESHOT_ACTION = DIE,
    parameter int         ADDR_W         = 18,
    parameter int         IDX_W          = 7,
    localparam int        SLOT_W         = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic              frame_start,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic              cfg_we,
    input  logic [SLOT_W-1:0] cfg_slot,
    input  logic [9:0]        cfg_x,
    input  logic [9:0]        cfg_y,
    input  logic [1:0]        cfg_type,
    input  logic [1:0]        cfg_action,
    input  logic              cfg_flip,
    input  logic              cfg_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [IDX_W-1:0]  rom_q,
    output logic [IDX_W-1:0]  pix_idx,
    output logic              pix_opaque
);

    logic [5:0]   div_cnt;
    logic         step;
    slot_cfg_t    cfg_word;
    logic [N_SLOTS-1:0] slot_hit;
    logic [19:0]  slot_addr [N_SLOTS];
    logic         any_hit;
    logic [19:0]  win_addr;
    logic         hit_d1, blank_d1, hit_d2, blank_d2;
    logic         opaque_next;

    assign step     = frame_start && (div_cnt == 6'(ANIM_DIV - 1));
    assign cfg_word = '{x: cfg_x, y: cfg_y, ztype: cfg_type, action: cfg_action,
                        flip: cfg_flip, en: cfg_en};

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n)
            div_cnt <= '0;
        else if (frame_start)
            div_cnt <= step ? '0 : div_cnt + 6'd1;
    end

    for (genvar s = 0; s < N_SLOTS; s++) begin : g_slot
        zombie_slot #(.ONESHOT_ACTION(ONESHOT_ACTION)) u_slot (
            .vga_clk     (vga_clk),
            .reset_n     (reset_n),
            .frame_start (frame_start),
            .step        (step),
            .shadow_we   (cfg_we && (cfg_slot == SLOT_W'(s))),
            .cfg         (cfg_word),
            .DrawX       (DrawX),
            .DrawY       (DrawY),
            .hit         (slot_hit[s]),
            .addr        (slot_addr[s])
        );
    end

    // Scan from the top so the lowest hitting index overwrites last and wins.
    always_comb begin
        any_hit  = 1'b0;
        win_addr = '0;
        for (int s = N_SLOTS - 1; s >= 0; s--) begin
            if (slot_hit[s]) begin
                any_hit  = 1'b1;
                win_addr = slot_addr[s];
            end
        end
    end

    assign opaque_next = hit_d2 && blank_d2 && (rom_q != IDX_W'(TRANSPARENT_IDX));

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr   <= '0;
            hit_d1     <= 1'b0;
            blank_d1   <= 1'b0;
            hit_d2     <= 1'b0;
            blank_d2   <= 1'b0;
            pix_idx    <= '0;
            pix_opaque <= 1'b0;
        end else begin
            rom_addr   <= any_hit ? ADDR_W'(win_addr) : '0;
            hit_d1     <= any_hit;
            blank_d1   <= blank;
            hit_d2     <= hit_d1;
            blank_d2   <= blank_d1;
            pix_idx    <= opaque_next ? rom_q : '0;
            pix_opaque <= opaque_next;
        end
    end

endmodule

// File: doc/zombie_sprite_engine.md
# zombie_sprite_engine

Multi-instance zombie sprite renderer for the VGA pixel path. Holds `N_SLOTS` independently positioned zombies, each with its own type, action, animation frame and horizontal flip. For every (DrawX, DrawY) it emits a sprite-sheet ROM address and returns a palette index plus an opaque flag three cycles later, for the top-level compositor to lay over the lawn background. Slot updates are double-buffered and committed at frame start, so the screen never tears.

## Interface
- `N_SLOTS`, 8: number of zombie instances (1..16).
- `ANIM_DIV`, 6: frames per animation step (1..63).
- `ONESHOT_ACTION`, 2: action code that plays once and holds its last frame; all other actions loop.
- `ADDR_W`, 18: ROM address width.
- `IDX_W`, 7: palette index width.

- `vga_clk` in 1: pixel clock. All logic on posedge.
- `reset_n` in 1: asynchronous, active-low reset.
- `frame_start` in 1: one-cycle pulse at the start of each frame (DrawX=0, DrawY=0).
- `DrawX`, `DrawY` in 10 each: current pixel.
- `blank` in 1: 1 = active video.
- `cfg_we` in 1: slot shadow write strobe.
- `cfg_slot` in $clog2(N_SLOTS): target slot.
- `cfg_x`, `cfg_y` in 10 each: sprite top-left corner.
- `cfg_type` in 2, `cfg_action` in 2, `cfg_flip` in 1, `cfg_en` in 1: zombie type, action row, horizontal mirror, slot visible.
- `rom_addr` out ADDR_W: sheet address (registered).
- `rom_q` in IDX_W: ROM data, valid exactly one cycle after `rom_addr`.
- `pix_idx` out IDX_W: palette index.
- `pix_opaque` out 1: 1 = a zombie covers this pixel.

## Operation
- Sheet geometry (package constants): FRAME_W=48, FRAME_H=64, FRAMES=4, SHEET_W=576, ACTION_STRIDE=192, TYPE_STRIDE=36864, TRANSPARENT_IDX=0.
- Per slot: a shadow register set written by `cfg_we`, and an active set loaded from shadow on `frame_start`.
- A `cfg_we` in the same cycle as `frame_start` updates shadow only. The commit uses the pre-write shadow, so the write appears one frame later.
- Global divider `div_cnt` counts 0..ANIM_DIV-1 on each `frame_start` and wraps. `step` is asserted when `div_cnt`=ANIM_DIV-1 and `frame_start` is high.
- Per-slot frame counter:
  - Cleared to 0 on a commit that changes type or action, or turns `en` 0→1. Clear has priority over `step`.
  - Otherwise, on `step`: looping actions advance (frame+1) mod FRAMES; ONESHOT_ACTION saturates at FRAMES-1.
- Hit test: dx = DrawX−x and dy = DrawY−y, computed in 11 bits. A hit requires en, DrawX≥x, DrawY≥y, dx<FRAME_W and dy<FRAME_H. Sprites may extend past the right and bottom edges; x and y are unsigned.
- Priority: the lowest-index hitting slot wins.
- Address: col = flip ? FRAME_W−1−dx : dx. addr = dy·SHEET_W + col + FRAME_W·frame + ACTION_STRIDE·action + TYPE_STRIDE·type, truncated to ADDR_W.
- When nothing hits, `rom_addr` is 0 and a miss flag travels down the pipe.
- Output: `pix_opaque` = hit ∧ blank ∧ (`rom_q` ≠ TRANSPARENT_IDX). `pix_idx` = `rom_q` when opaque, else 0.
- A transparent pixel of the winning slot does not fall through to lower-priority slots.

## Timing
- Stage 1 (cycle n+1): hit/priority/address registered into `rom_addr`, with hit and blank delayed alongside.
- Stage 2 (n+2): `rom_q` valid.
- Stage 3 (n+3): `pix_idx` and `pix_opaque` registered.
- Total latency: 3 cycles from DrawX/DrawY to output. Throughput is one pixel per clock, with no stalls.
- Reset values: `rom_addr`=0, `pix_idx`=0, `pix_opaque`=0. Pipeline hit/blank flags are 0. All shadow and active slots have en=0, x=y=0, type=action=flip=0. All frame counters and `div_cnt` are 0.
- Reset asserted mid-frame clears everything immediately. Output stays non-opaque until a `frame_start` commits fresh configuration.
- Active-set changes take effect for pixels presented on or after the `frame_start` cycle.

## Structure
- Package `zombie_pkg`:
  - sheet constants listed above;
  - `slot_cfg_t` packed struct {x, y, type, action, flip, en};
  - `zombie_action_e` enum (WALK, EAT, DIE).
- Sub-module `zombie_slot` (instantiated N_SLOTS times) holds:
  - the shadow and active `slot_cfg_t`;
  - the frame counter with clear/step logic;
  - the combinational hit flag and per-slot address.
- The top level holds `div_cnt`, the priority mux and the pipeline registers.

## Test plan
- After reset, write slot 0 {x=100, y=200, type=1, action=0, flip=0, en=1}, then pulse `frame_start`.
  - Pixel (100,200) → `rom_addr`=36864 one cycle later.
  - With `rom_q`=5, `pix_idx`=5 and `pix_opaque`=1 at n+3.
- Flip=1 on the same slot → pixel (100,200) yields `rom_addr`=36864+47.
- Animation with ANIM_DIV=6, action 0:
  - frame advances after 6 `frame_start` pulses and wraps 3→0 after 24;
  - with action 2, frame holds at 3.
- Overlap: slot 0 and slot 3 both cover (300,300) → address is computed from slot 0's geometry; `rom_q`=0 → `pix_opaque`=0.
- `cfg_we` coincident with `frame_start` → new x visible only after the next `frame_start`.
- `blank`=0 with a hit → `pix_opaque`=0.
- Asserting `reset_n` low mid-line → all outputs 0 within the same cycle.
